fwd_hazard_unit: RTL and testbench
==================================

# fwd_hazard_unit

Parametrised forwarding and hazard unit for the 5-stage pipeline: the successor to the purely combinational forwarding select logic. It tracks destination and source tags for the EX, MEM and WB stages internally, so the datapath only presents the instruction in ID. It produces per-operand forwarding selects, a one-cycle load-use stall, and a multi-cycle freeze while a load waits on data memory. It sits beside the ID/EX control path and drives the EX operand muxes and the pipeline-register enables.

## Interface
- REG_AW, default 4: register-address width.
- NUM_SRC, default 2: source operands per instruction; the EX stage has one forwarding mux per operand.
- LOAD_LAT, default 1: extra MEM cycles a load needs, range 0..3.

- clk  in  1  pipeline clock.
- rst_n  in  1  reset, asynchronous and active-low.
- id_valid  in  1  ID holds a real instruction.
- id_src  in  NUM_SRC*REG_AW  source registers; operand i is in bits [i*REG_AW +: REG_AW].
- id_dst  in  REG_AW  destination register.
- id_wr  in  1  instruction writes the register file.
- id_is_load  in  1  instruction is a load.
- flush  in  1  squash the ID instruction (taken branch).
- fwd_sel  out  NUM_SRC*2  per-operand EX select: 00 = regfile/ID-EX value, 10 = EX/MEM, 01 = MEM/WB.
- stall_id  out  1  hold the PC and IF/ID.
- bubble_ex  out  1  load a NOP into ID/EX.
- stall_mem  out  1  freeze ID/EX, EX/MEM and MEM/WB.

## Operation
- **Tag stages.** EX, MEM and WB each hold {valid, wr, load, dst, src[NUM_SRC]}.
- **Tag advance.** On every clk edge with stall_mem=0:
  - WB<=MEM and MEM<=EX.
  - EX<=ID fields only if id_valid && !load_use && !flush; otherwise EX.valid<=0.
- **Freeze.** With stall_mem=1, all tags hold and flush is ignored. The branch source must hold flush until stall_mem=0.
- **load_use.** Asserted when EX.valid && EX.load && EX.wr && EX.dst!=0 && id_valid, and EX.dst equals any id_src[i].
- **Stall outputs.**
  - stall_id = stall_mem | (load_use & !flush).
  - bubble_ex = load_use & !flush & !stall_mem.
- **Forwarding select for operand i** (combinational from registered tags; 00 whenever EX.valid=0):
  - 10 if MEM.valid && MEM.wr && !MEM.load && MEM.dst!=0 && MEM.dst==EX.src[i].
  - else 01 if WB.valid && WB.wr && WB.dst!=0 && WB.dst==EX.src[i].
  - else 00.
- **Priority.** EX/MEM beats MEM/WB. Register 0 is never forwarded.
- **Memory-wait FSM**, states RUN and MEM_WAIT, with a 2-bit counter cnt:
  - RUN -> MEM_WAIT on the edge where a valid load advances EX->MEM and LOAD_LAT>0; cnt<=LOAD_LAT-1.
  - MEM_WAIT: cnt decrements each cycle; MEM_WAIT -> RUN when cnt==0.
  - stall_mem = (state==MEM_WAIT).
- **Register-file writes during a freeze.** The WB stage re-writes the same value on each frozen cycle; this is harmless.

## Timing
- **Reset.** All tag valids 0, state RUN, cnt 0.
  - Outputs: fwd_sel all 00, stall_id 0, bubble_ex 0, stall_mem 0.
  - Reset takes effect immediately, including mid-MEM_WAIT.
- **Output paths.** fwd_sel is valid in the same cycle the consumer's tag occupies EX. It has no combinational path from ID inputs.
- **Load-use.** Exactly one bubble cycle, then stall_mem for LOAD_LAT cycles. The consumer reaches EX the cycle the load reaches WB and gets 01.
- **Simultaneous load_use and flush.** Flush wins: no stall, EX gets a bubble.
- **LOAD_LAT=0.** The FSM never leaves RUN.
- **Back-to-back loads.** Each load incurs its own MEM_WAIT.

## Structure
- **Shared package fwd_pkg:**
  - FWD_REGFILE=2'b00, FWD_EXMEM=2'b10, FWD_MEMWB=2'b01.
  - FSM state enum {RUN, MEM_WAIT}.
  - Stage-tag struct typedef, parametrised by REG_AW/NUM_SRC via the module.
- **Sub-module fwd_select.** One operand's priority compare, instantiated NUM_SRC times in a generate loop.

## Test plan
(REG_AW=4, NUM_SRC=2, LOAD_LAT=2 unless noted.)
- **Reset mid-freeze.** Assert rst_n=0 while stall_mem=1 -> all outputs 0 without waiting for clk. After release, the next ID instruction enters EX with fwd_sel=0000.
- **EX/MEM priority.** I1 wr r3, I2 wr r3, I3 src0=r3 -> when I3 is in EX, fwd_sel[1:0]=10 (not 01).
- **WB forward.** I1 wr r5, NOP, I3 src1=r5 -> when I3 is in EX, fwd_sel[3:2]=01 and fwd_sel[1:0]=00.
- **Register 0.** I1 wr r0, I2 src0=src1=r0 -> fwd_sel=0000 and no stall.
- **Load-use with latency.** Load r7 then consumer src0=r7:
  - cycle t: stall_id=1, bubble_ex=1.
  - t+1..t+2: stall_mem=1, stall_id=1.
  - t+3: all 0.
  - t+4: consumer in EX with fwd_sel[1:0]=01.
  - Repeat with LOAD_LAT=0 -> a single bubble and stall_mem never asserts.
- **Flush.**
  - Consumer of an EX load in ID with flush=1 -> stall_id=0, bubble_ex=0, EX invalid next cycle, fwd_sel=0000.
  - flush asserted during stall_mem is ignored until release.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared definitions for the forwarding/hazard unit: EX operand-mux select
// codes and the memory-wait FSM state type.
package fwd_pkg;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_EXMEM   = 2'b10;
  localparam logic [1:0] FWD_MEMWB   = 2'b01;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } mw_state_t;

endpackage

// File: rtl/fwd_hazard_unit_select.sv
// Priority forwarding compare for a single EX operand.
// EX/MEM wins over MEM/WB, loads in MEM have no data yet, and r0 is never
// forwarded.
module fwd_select
  import fwd_pkg::*;
#(
  parameter int REG_AW = 4
) (
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] ex_src,
  input  logic              mem_valid,
  input  logic              mem_wr,
  input  logic              mem_load,
  input  logic [REG_AW-1:0] mem_dst,
  input  logic              wb_valid,
  input  logic              wb_wr,
  input  logic [REG_AW-1:0] wb_dst,
  output logic [1:0]        sel
);

  // choose the youngest older producer of this operand
  always_comb begin
    sel = FWD_REGFILE;
    if (ex_valid) begin
      if (mem_valid && mem_wr && !mem_load && (mem_dst != '0) && (mem_dst == ex_src)) begin
        sel = FWD_EXMEM;
      end else if (wb_valid && wb_wr && (wb_dst != '0) && (wb_dst == ex_src)) begin
        sel = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit for the 5-stage pipeline. Tracks EX/MEM/WB
// instruction tags internally and produces EX operand selects, the load-use
// stall/bubble and the data-memory wait freeze.
//
// Memory-wait FSM:
//   state    | meaning
//   RUN      | pipeline advances normally
//   MEM_WAIT | load in MEM waiting on data memory; cnt counts down to release
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_AW   = 4,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [REG_AW-1:0]         id_dst,
  input  logic                      id_wr,
  input  logic                      id_is_load,
  input  logic                      flush,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic                      stall_id,
  output logic                      bubble_ex,
  output logic                      stall_mem
);

  typedef struct packed {
    logic                      valid;
    logic                      wr;
    logic                      load;
    logic [REG_AW-1:0]         dst;
    logic [NUM_SRC*REG_AW-1:0] src;
  } tag_t;

  // LOAD_LAT is limited to 0..3, so LOAD_LAT-1 always fits the 2-bit counter
  localparam logic [1:0] CNT_INIT = (LOAD_LAT > 0) ? 2'(LOAD_LAT - 1) : 2'd0;

  tag_t      ex_q, mem_q, wb_q, id_tag;
  mw_state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic      src_hit, load_use;
  logic      unused_tags;

  assign id_tag = {id_valid, id_wr, id_is_load, id_dst, id_src};

  // does any ID source read the register the EX-stage load is producing
  always_comb begin
    src_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_src[i*REG_AW +: REG_AW] == ex_q.dst) src_hit = 1'b1;
    end
  end

  assign load_use  = ex_q.valid && ex_q.load && ex_q.wr && (ex_q.dst != '0) && id_valid && src_hit;
  assign stall_mem = (state_q == MEM_WAIT);
  assign stall_id  = stall_mem | (load_use & ~flush);
  assign bubble_ex = load_use & ~flush & ~stall_mem;

  // tag pipeline: everything holds while the memory wait freezes the pipe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!stall_mem) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (id_valid && !load_use && !flush) ex_q <= id_tag;
      else                                 ex_q <= '0;
    end
  end

  // memory-wait state and countdown register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // enter the wait when a load moves into MEM; leave on terminal count
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if ((LOAD_LAT > 0) && ex_q.valid && ex_q.load) begin
          state_d = MEM_WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      MEM_WAIT: begin
        if (cnt_q == 2'd0) state_d = RUN;
        else               cnt_d   = cnt_q - 2'd1;
      end
      default: state_d = RUN;
    endcase
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_sel
    fwd_select #(.REG_AW(REG_AW)) u_sel (
      .ex_valid  (ex_q.valid),
      .ex_src    (ex_q.src[g*REG_AW +: REG_AW]),
      .mem_valid (mem_q.valid),
      .mem_wr    (mem_q.wr),
      .mem_load  (mem_q.load),
      .mem_dst   (mem_q.dst),
      .wb_valid  (wb_q.valid),
      .wb_wr     (wb_q.wr),
      .wb_dst    (wb_q.dst),
      .sel       (fwd_sel[g*2 +: 2])
    );
  end

  // WB load flag and the MEM/WB source fields are carried for completeness only
  assign unused_tags = ^{wb_q.load, wb_q.src, mem_q.src};

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0, id_wr = 1'b0, id_is_load = 1'b0, flush = 1'b0;
  logic [7:0] id_src = '0;
  logic [3:0] id_dst = '0;
  logic [3:0] fwd_sel, fwd_sel0;
  logic       stall_id, bubble_ex, stall_mem;
  logic       stall_id0, bubble_ex0, stall_mem0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.REG_AW(4), .NUM_SRC(2), .LOAD_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src), .id_dst(id_dst),
    .id_wr(id_wr), .id_is_load(id_is_load), .flush(flush),
    .fwd_sel(fwd_sel), .stall_id(stall_id), .bubble_ex(bubble_ex), .stall_mem(stall_mem)
  );

  fwd_hazard_unit #(.REG_AW(4), .NUM_SRC(2), .LOAD_LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src), .id_dst(id_dst),
    .id_wr(id_wr), .id_is_load(id_is_load), .flush(flush),
    .fwd_sel(fwd_sel0), .stall_id(stall_id0), .bubble_ex(bubble_ex0), .stall_mem(stall_mem0)
  );

  // ---------------- reference model (index 0: LOAD_LAT=2, index 1: LOAD_LAT=0)
  typedef struct {
    bit v; bit wr; bit ld; int dst; int s0; int s1;
  } ins_t;

  ins_t m_ex[2], m_mem[2], m_wb[2];
  int   m_wait[2];
  int   m_lat[2];

  function automatic ins_t empty_ins();
    ins_t r;
    r.v = 0; r.wr = 0; r.ld = 0; r.dst = 0; r.s0 = 0; r.s1 = 0;
    return r;
  endfunction

  function automatic ins_t cur_ins();
    ins_t r;
    r.v = id_valid; r.wr = id_wr; r.ld = id_is_load; r.dst = int'(id_dst);
    r.s0 = int'(id_src[3:0]); r.s1 = int'(id_src[7:4]);
    return r;
  endfunction

  function automatic bit m_load_use(int k);
    ins_t c = cur_ins();
    return m_ex[k].v && m_ex[k].ld && m_ex[k].wr && (m_ex[k].dst != 0) && c.v &&
           ((m_ex[k].dst == c.s0) || (m_ex[k].dst == c.s1));
  endfunction

  // 2 = EX/MEM (10), 1 = MEM/WB (01), 0 = regfile
  function automatic int m_fwd_one(int k, int src);
    if (!m_ex[k].v) return 0;
    if (m_mem[k].v && m_mem[k].wr && !m_mem[k].ld && m_mem[k].dst != 0 && m_mem[k].dst == src) return 2;
    if (m_wb[k].v && m_wb[k].wr && m_wb[k].dst != 0 && m_wb[k].dst == src) return 1;
    return 0;
  endfunction

  function automatic logic [6:0] m_expect(int k);
    bit frozen = (m_wait[k] > 0);
    bit lu = m_load_use(k);
    logic [3:0] f = {2'(m_fwd_one(k, m_ex[k].s1)), 2'(m_fwd_one(k, m_ex[k].s0))};
    return {f, frozen || (lu && !flush), lu && !flush && !frozen, frozen};
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_ex[k] = empty_ins(); m_mem[k] = empty_ins(); m_wb[k] = empty_ins(); m_wait[k] = 0;
    end
  endtask

  task automatic m_step();
    bit lu;
    for (int k = 0; k < 2; k++) begin
      lu = m_load_use(k);
      if (m_wait[k] > 0) begin
        m_wait[k]--;
      end else begin
        if (m_ex[k].v && m_ex[k].ld && m_lat[k] > 0) m_wait[k] = m_lat[k];
        m_wb[k]  = m_mem[k];
        m_mem[k] = m_ex[k];
        if (id_valid && !lu && !flush) m_ex[k] = cur_ins();
        else                           m_ex[k] = empty_ins();
      end
    end
  endtask

  // ---------------- stimulus helpers
  task automatic drive(bit v, int dst, bit wr, bit ld, int s0, int s1, bit fl);
    id_valid = v; id_dst = 4'(dst); id_wr = wr; id_is_load = ld;
    id_src = {4'(s1), 4'(s0)}; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic idle(int n);
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (n) tick();
  endtask

  // ---------------- tests
  task automatic test_reset();
    rst_n = 1'b0;
    m_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    n_cmp++; if (fwd_sel !== 4'b0000) begin n_err++; $display("FAIL reset_fwd: got %b want 0000", fwd_sel); end
    n_cmp++; if ({stall_id, bubble_ex, stall_mem} !== 3'b000) begin n_err++; $display("FAIL reset_stalls: got %b want 000", {stall_id, bubble_ex, stall_mem}); end
    n_cmp++; if ({fwd_sel0, stall_id0, bubble_ex0, stall_mem0} !== 7'd0) begin n_err++; $display("FAIL reset_lat0: got %b want 0000000", {fwd_sel0, stall_id0, bubble_ex0, stall_mem0}); end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_ex_mem_priority();
    idle(4);
    drive(1, 3, 1, 0, 1, 2, 0); tick();
    drive(1, 3, 1, 0, 1, 2, 0); tick();
    drive(1, 6, 1, 0, 3, 9, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_cmp++; if (fwd_sel !== 4'b0010) begin n_err++; $display("FAIL exmem_priority: got %b want 0010", fwd_sel); end
    n_cmp++; if (fwd_sel0 !== 4'b0010) begin n_err++; $display("FAIL exmem_priority_lat0: got %b want 0010", fwd_sel0); end
    tick();
  endtask

  task automatic test_wb_forward();
    idle(4);
    drive(1, 5, 1, 0, 1, 2, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 6, 1, 0, 2, 5, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_cmp++; if (fwd_sel !== 4'b0100) begin n_err++; $display("FAIL wb_forward: got %b want 0100", fwd_sel); end
    tick();
  endtask

  task automatic test_reg_zero();
    idle(4);
    drive(1, 0, 1, 0, 1, 2, 0); tick();
    drive(1, 6, 1, 0, 0, 0, 0);
    @(negedge clk);
    n_cmp++; if (stall_id !== 1'b0) begin n_err++; $display("FAIL r0_stall: got %b want 0", stall_id); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_cmp++; if (fwd_sel !== 4'b0000) begin n_err++; $display("FAIL r0_fwd: got %b want 0000", fwd_sel); end
    tick();
  endtask

  task automatic test_load_use();
    idle(6);
    drive(1, 7, 1, 1, 1, 2, 0); tick();
    drive(1, 8, 1, 0, 7, 1, 0);
    @(negedge clk);
    n_cmp++; if ({stall_id, bubble_ex, stall_mem} !== 3'b110) begin n_err++; $display("FAIL lu_t: got %b want 110", {stall_id, bubble_ex, stall_mem}); end
    n_cmp++; if ({stall_id0, bubble_ex0, stall_mem0} !== 3'b110) begin n_err++; $display("FAIL lu_t_lat0: got %b want 110", {stall_id0, bubble_ex0, stall_mem0}); end
    tick();
    @(negedge clk);
    n_cmp++; if ({stall_id, bubble_ex, stall_mem} !== 3'b101) begin n_err++; $display("FAIL lu_t1: got %b want 101", {stall_id, bubble_ex, stall_mem}); end
    n_cmp++; if ({stall_id0, bubble_ex0, stall_mem0} !== 3'b000) begin n_err++; $display("FAIL lu_t1_lat0: got %b want 000", {stall_id0, bubble_ex0, stall_mem0}); end
    tick();
    @(negedge clk);
    n_cmp++; if ({stall_id, bubble_ex, stall_mem} !== 3'b101) begin n_err++; $display("FAIL lu_t2: got %b want 101", {stall_id, bubble_ex, stall_mem}); end
    n_cmp++; if (stall_mem0 !== 1'b0) begin n_err++; $display("FAIL lu_t2_lat0_mem: got %b want 0", stall_mem0); end
    tick();
    @(negedge clk);
    n_cmp++; if ({stall_id, bubble_ex, stall_mem} !== 3'b000) begin n_err++; $display("FAIL lu_t3: got %b want 000", {stall_id, bubble_ex, stall_mem}); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_cmp++; if (fwd_sel !== 4'b0001) begin n_err++; $display("FAIL lu_t4_fwd: got %b want 0001", fwd_sel); end
    tick();
  endtask

  task automatic test_flush();
    idle(6);
    drive(1, 9, 1, 0, 1, 2, 0); tick();
    drive(1, 7, 1, 1, 1, 2, 0); tick();
    drive(1, 8, 1, 0, 9, 7, 1);
    @(negedge clk);
    n_cmp++; if ({stall_id, bubble_ex} !== 2'b00) begin n_err++; $display("FAIL flush_no_stall: got %b want 00", {stall_id, bubble_ex}); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_cmp++; if (fwd_sel !== 4'b0000) begin n_err++; $display("FAIL flush_ex_empty: got %b want 0000", fwd_sel); end
    n_cmp++; if (stall_mem !== 1'b1) begin n_err++; $display("FAIL flush_load_wait: got %b want 1", stall_mem); end
    tick();
  endtask

  task automatic test_flush_during_freeze();
    idle(6);
    drive(1, 7, 1, 1, 1, 2, 0); tick();
    drive(1, 4, 1, 0, 1, 2, 0); tick();
    drive(1, 5, 1, 0, 3, 3, 1);
    @(negedge clk);
    n_cmp++; if ({stall_id, bubble_ex, stall_mem} !== 3'b101) begin n_err++; $display("FAIL ff_f1: got %b want 101", {stall_id, bubble_ex, stall_mem}); end
    tick();
    @(negedge clk);
    n_cmp++; if (stall_mem !== 1'b1) begin n_err++; $display("FAIL ff_f2: got %b want 1", stall_mem); end
    tick();
    @(negedge clk);
    n_cmp++; if ({stall_id, stall_mem} !== 2'b00) begin n_err++; $display("FAIL ff_release: got %b want 00", {stall_id, stall_mem}); end
    tick();
    drive(1, 6, 1, 0, 4, 5, 0);
    @(negedge clk);
    n_cmp++; if (fwd_sel !== 4'b0000) begin n_err++; $display("FAIL ff_bubble: got %b want 0000", fwd_sel); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_cmp++; if (fwd_sel !== 4'b0001) begin n_err++; $display("FAIL ff_kept_ex: got %b want 0001", fwd_sel); end
    tick();
  endtask

  task automatic test_random();
    logic [6:0] exp_v;
    idle(6);
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 4) != 0,
            $urandom_range(0, 9) < 3, $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 9) == 0);
      @(negedge clk);
      exp_v = m_expect(0);
      n_cmp++; if ({fwd_sel, stall_id, bubble_ex, stall_mem} !== exp_v) begin n_err++; $display("FAIL rand_lat2 cyc %0d: got %b want %b", c, {fwd_sel, stall_id, bubble_ex, stall_mem}, exp_v); end
      exp_v = m_expect(1);
      n_cmp++; if ({fwd_sel0, stall_id0, bubble_ex0, stall_mem0} !== exp_v) begin n_err++; $display("FAIL rand_lat0 cyc %0d: got %b want %b", c, {fwd_sel0, stall_id0, bubble_ex0, stall_mem0}, exp_v); end
      tick();
    end
  endtask

  task automatic test_reset_mid_freeze();
    idle(6);
    drive(1, 7, 1, 1, 1, 2, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    @(negedge clk);
    n_cmp++; if (stall_mem !== 1'b1) begin n_err++; $display("FAIL rmf_pre: got %b want 1", stall_mem); end
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    n_cmp++; if ({fwd_sel, stall_id, bubble_ex, stall_mem} !== 7'd0) begin n_err++; $display("FAIL rmf_async: got %b want 0000000", {fwd_sel, stall_id, bubble_ex, stall_mem}); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1, 9, 1, 0, 7, 7, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_cmp++; if ({fwd_sel, stall_mem} !== 5'b00000) begin n_err++; $display("FAIL rmf_after: got %b want 00000", {fwd_sel, stall_mem}); end
    tick();
  endtask

  initial begin
    m_lat[0] = 2;
    m_lat[1] = 0;
    test_reset();
    test_ex_mem_priority();
    test_wb_forward();
    test_reg_zero();
    test_load_use();
    test_flush();
    test_flush_during_freeze();
    test_random();
    test_reset_mid_freeze();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
